// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer driven by a one-cycle prescaler tick.
// Decrements with ripple borrow while running and flags expiry at zero.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [W-1:0] count_next;
    logic [W-1:0] sat_val;
    logic [W-1:0] dec_val;
    logic         dec_borrow;
    logic         done_next;
    logic         is_one;
    logic         is_zero;

    // Out-of-range digits on the preset clamp to 9 so count is always valid BCD.
    always_comb begin
        sat_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            sat_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    always_comb begin
        dec_val    = '0;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = count[4*i +: 4];
            end
        end
    end

    assign is_one  = (count == W'(1));
    assign is_zero = (count == '0);

    // Priority: load > pause > start > tick_in.
    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
        if (load) begin
            count_next = sat_val;
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !is_zero) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSED;
                    end else if (tick_in) begin
                        count_next = dec_val;
                        if (is_one) begin
                            state_next = ST_EXPIRED;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_EXPIRED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    assign running = (state == ST_RUN);
    assign expired = (state == ST_EXPIRED);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer with a scoreboard of expected outputs,
// covering a 2-digit and a 3-digit instance.
module tb_bcd_down_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_in, load, start, pause;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic        running, expired, done;

    logic        tick3, load3, start3, pause3;
    logic [11:0] load_val3;
    logic [11:0] count3;
    logic        running3, expired3, done3;

    typedef struct packed {
        logic [11:0] cnt;
        logic        run;
        logic        exp;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count), .running(running),
        .expired(expired), .done(done)
    );

    bcd_down_timer #(.DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .tick_in(tick3), .load(load3), .load_val(load_val3),
        .start(start3), .pause(pause3), .count(count3), .running(running3),
        .expired(expired3), .done(done3)
    );

    always #5 clk = ~clk;

    // Independent reference: convert to binary, subtract, convert back.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        int n;
        n = int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic expect_out(input logic [11:0] c, input logic r, input logic e, input logic d);
        exp_t x;
        x.cnt = c; x.run = r; x.exp = e; x.dn = d;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic st,
                                 input logic ps, input logic tk);
        load = ld; load_val = lv; start = st; pause = ps; tick_in = tk;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick_in = 1'b0;
    endtask

    task automatic applyStimulus3(input logic ld, input logic [11:0] lv, input logic st,
                                  input logic tk);
        load3 = ld; load_val3 = lv; start3 = st; pause3 = 1'b0; tick3 = tk;
        @(posedge clk);
        #1;
        load3 = 1'b0; start3 = 1'b0; tick3 = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input bit use3);
        exp_t e, o;
        if (use3) o = {count3, running3, expired3, done3};
        else      o = {4'h0, count, running, expired, done};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s: scoreboard empty, observed cnt=%h", tag, o.cnt);
            return;
        end
        e = sb.pop_front();
        assert (o === e) else begin
            failures++;
            $error("[TB] FAIL %s: observed cnt=%h run=%b exp=%b done=%b, expected cnt=%h run=%b exp=%b done=%b",
                   tag, o.cnt, o.run, o.exp, o.dn, e.cnt, e.run, e.exp, e.dn);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] model;
        rst = 1'b1;
        tick_in = 0; load = 0; start = 0; pause = 0; load_val = 8'h00;
        tick3 = 0; load3 = 0; start3 = 0; pause3 = 0; load_val3 = 12'h000;
        @(posedge clk);
        #1;
        expect_out(12'h000, 0, 0, 0); checkOutput("reset_state", 0);
        rst = 1'b0;

        // Plan 1: count down a bit, then async reset between edges.
        expect_out(12'h037, 0, 0, 0); applyStimulus(1, 8'h37, 0, 0, 0); checkOutput("load_37", 0);
        expect_out(12'h037, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_37", 0);
        expect_out(12'h036, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("tick_36", 0);
        expect_out(12'h035, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("tick_35", 0);
        expect_out(12'h034, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("tick_34", 0);
        #2;
        rst = 1'b1;
        #1;
        expect_out(12'h000, 0, 0, 0); checkOutput("async_reset_midcycle", 0);
        @(posedge clk);
        #1;
        expect_out(12'h000, 0, 0, 0); checkOutput("reset_no_done", 0);
        rst = 1'b0;

        // Plan 2: 12 spaced ticks from 0x12 down to expiry.
        expect_out(12'h012, 0, 0, 0); applyStimulus(1, 8'h12, 0, 0, 0); checkOutput("load_12", 0);
        expect_out(12'h012, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_12", 0);
        model = 8'h12;
        for (int i = 1; i <= 12; i++) begin
            model = bcd_dec(model);
            if (i == 12) expect_out({4'h0, model}, 0, 1, 1);
            else         expect_out({4'h0, model}, 1, 0, 0);
            applyStimulus(0, 8'h00, 0, 0, 1);
            checkOutput($sformatf("seq_tick_%0d", i), 0);
            idle_cycles(8);
            if (i == 12) expect_out(12'h000, 0, 1, 0);
            else         expect_out({4'h0, model}, 1, 0, 0);
            applyStimulus(0, 8'h00, 0, 0, 0);
            checkOutput($sformatf("seq_hold_%0d", i), 0);
        end

        // Plan 3: borrow ripple on both widths.
        expect_out(12'h020, 0, 0, 0); applyStimulus(1, 8'h20, 0, 0, 0); checkOutput("load_20", 0);
        expect_out(12'h020, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_20", 0);
        expect_out(12'h019, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("borrow_19", 0);
        expect_out(12'h100, 0, 0, 0); applyStimulus3(1, 12'h100, 0, 0); checkOutput("d3_load_100", 1);
        expect_out(12'h100, 1, 0, 0); applyStimulus3(0, 12'h000, 1, 0); checkOutput("d3_start", 1);
        expect_out(12'h099, 1, 0, 0); applyStimulus3(0, 12'h000, 0, 1); checkOutput("d3_borrow_099", 1);

        // Plan 4: pause beats tick, paused ignores ticks, resume to expiry.
        expect_out(12'h005, 0, 0, 0); applyStimulus(1, 8'h05, 0, 0, 0); checkOutput("load_05", 0);
        expect_out(12'h005, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_05", 0);
        expect_out(12'h004, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("tick_04", 0);
        expect_out(12'h003, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("tick_03", 0);
        expect_out(12'h003, 0, 0, 0); applyStimulus(0, 8'h00, 0, 1, 1); checkOutput("pause_with_tick", 0);
        for (int i = 0; i < 5; i++) begin
            expect_out(12'h003, 0, 0, 0);
            applyStimulus(0, 8'h00, 0, 0, 1);
            checkOutput($sformatf("paused_tick_%0d", i), 0);
        end
        expect_out(12'h003, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("resume", 0);
        expect_out(12'h002, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("resume_tick_02", 0);
        expect_out(12'h001, 1, 0, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("resume_tick_01", 0);
        expect_out(12'h000, 0, 1, 1); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("resume_expire", 0);

        // Plan 5: saturating load and start-from-zero.
        expect_out(12'h099, 0, 0, 0); applyStimulus(1, 8'hAF, 0, 0, 0); checkOutput("saturate_AF", 0);
        expect_out(12'h000, 0, 0, 0); applyStimulus(1, 8'h00, 0, 0, 0); checkOutput("load_00", 0);
        expect_out(12'h000, 0, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_zero_idle", 0);

        // Plan 6: expired is sticky; load interrupts a run.
        expect_out(12'h001, 0, 0, 0); applyStimulus(1, 8'h01, 0, 0, 0); checkOutput("load_01", 0);
        expect_out(12'h001, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_01", 0);
        expect_out(12'h000, 0, 1, 1); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("expire_01", 0);
        expect_out(12'h000, 0, 1, 0); applyStimulus(0, 8'h00, 1, 0, 1); checkOutput("expired_start_tick", 0);
        expect_out(12'h000, 0, 1, 0); applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("expired_tick", 0);
        expect_out(12'h042, 0, 0, 0); applyStimulus(1, 8'h42, 0, 0, 0); checkOutput("load_42", 0);
        expect_out(12'h042, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("start_42", 0);
        expect_out(12'h041, 1, 0, 0); applyStimulus(0, 8'h00, 1, 0, 1); checkOutput("run_start_ignored", 0);
        expect_out(12'h042, 0, 0, 0); applyStimulus(1, 8'h42, 0, 1, 1); checkOutput("load_during_run", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
